// File: rtl/serial_subtractor_8bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_subtractor_8bit: bit-serial A - B, LSB first, eight clocks each    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module serial_subtractor_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Diff,
  output logic       Bout,
  output logic       Ovf,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  a_sh;
  logic [7:0]  b_sh;
  logic [7:0]  res;
  logic [2:0]  cnt;
  logic        br;
  logic        a_msb;
  logic        b_msb;

  logic        d_bit;
  logic        br_next;
  logic [7:0]  res_next;

  // One full-subtractor cell applied to the current LSBs.
  assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign res_next = {d_bit, res[7:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= 8'h00;
      b_sh  <= 8'h00;
      res   <= 8'h00;
      cnt   <= 3'd0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Diff  <= 8'h00;
      Bout  <= 1'b0;
      Ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            a_msb <= A[7];
            b_msb <= B[7];
            res   <= 8'h00;
            cnt   <= 3'd0;
            br    <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          a_sh <= {1'b0, a_sh[7:1]};
          b_sh <= {1'b0, b_sh[7:1]};
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + 3'd1;
          // The eighth bit completes the result; publish it on this same edge.
          if (cnt == 3'd7) begin
            Diff  <= res_next;
            Bout  <= br_next;
            Ovf   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_8bit.sv
`default_nettype none
// Scoreboard bench for serial_subtractor_8bit: arithmetic reference model,
// directed corner cases followed by random operands.
module tb_serial_subtractor_8bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Diff;
  logic       Bout;
  logic       Ovf;
  logic       busy;
  logic       done;

  serial_subtractor_8bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Diff (Diff),
    .Bout (Bout),
    .Ovf  (Ovf),
    .busy (busy),
    .done (done)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t q[$];
  exp_t held;
  bit   mon_en;
  int   checks;
  int   passed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   sa;
    int   sb;
    sa   = $signed(a);
    sb   = $signed(b);
    e.d  = a - b;
    e.bo = (a < b);
    e.ov = ((sa - sb) > 127) || ((sa - sb) < -128);
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse, otherwise checks hold.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          held = q.pop_front();
          check("diff", {24'd0, Diff}, {24'd0, held.d});
          check("bout", {31'd0, Bout}, {31'd0, held.bo});
          check("ovf",  {31'd0, Ovf},  {31'd0, held.ov});
        end
      end else begin
        check("hold", {23'd0, Diff, Bout, Ovf}, {23'd0, held.d, held.bo, held.ov});
      end
    end
  end

  // Issue one request from a negedge; returns at the negedge after done
  // (or after the abort reset). hold keeps start high, poke fires an
  // extra start with other operands mid-operation, abort resets mid-shift.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input bit hold, input bit poke, input bit abort);
    int t;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    A     = a;
    B     = b;
    start = 1'b1;
    if (!abort) q.push_back(model(a, b));
    @(negedge clk);
    start = hold;
    A     = 8'($urandom);
    B     = 8'($urandom);
    if (abort) begin
      repeat (3) @(negedge clk);
      rst_n  = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      check("abort_diff", {24'd0, Diff}, 32'd0);
      check("abort_flags", {29'd0, Bout, Ovf, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      rst_n  = 1'b1;
      held   = '0;
      mon_en = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_stays_idle", {30'd0, busy, done}, 32'd0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        check("busy_during_shift", {31'd0, busy}, 32'd1);
        check("no_early_done", {31'd0, done}, 32'd0);
        if (poke && i == 2) begin
          start = 1'b1;
          A     = 8'h11;
          B     = 8'h22;
        end
        if (poke && i == 3) start = hold;
        @(negedge clk);
      end
      check("done_latency", {31'd0, done}, 32'd1);
      check("busy_in_done", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    mon_en = 1'b0;
    held   = '0;
    rst_n  = 1'b0;
    start  = 1'b1;
    A      = 8'h12;
    B      = 8'h34;
    repeat (3) @(negedge clk);
    check("rst_diff", {24'd0, Diff}, 32'd0);
    check("rst_flags", {28'd0, Bout, Ovf, busy, done}, 32'd0);
    start  = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    issue(8'h98, 8'hAA, 0, 0, 0);
    repeat (2) @(negedge clk);
    issue(8'hAA, 8'h9F, 0, 0, 0);
    issue(8'h80, 8'h01, 0, 0, 0);
    issue(8'h00, 8'h01, 0, 0, 0);
    issue(8'h55, 8'h55, 0, 0, 0);
    issue(8'h7F, 8'hFF, 0, 0, 0);
    repeat (3) @(negedge clk);
    issue(8'h98, 8'hAA, 0, 1, 0);
    repeat (3) @(negedge clk);
    issue(8'h98, 8'hAA, 0, 0, 1);
    issue(8'hAA, 8'h9F, 0, 0, 0);

    for (int i = 0; i < 4; i++) issue(8'h80, 8'h01, 1, 0, 0);
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom), 0, ($urandom_range(0, 3) == 0), 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    check("scoreboard_empty", q.size(), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor_8bit.md
SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request pulse; operands are captured when the request is accepted.
REQ-005 A  input  8  minuend, unsigned or two's complement.
REQ-006 B  input  8  subtrahend, unsigned or two's complement.
REQ-007 Diff  output  8  registered result, A - B mod 256.
REQ-008 Bout  output  1  registered borrow-out, 1 when A < B unsigned.
REQ-009 Ovf  output  1  registered signed overflow of A - B.
REQ-010 busy  output  1  high while a subtraction is in progress.
REQ-011 done  output  1  one-cycle pulse; Diff, Bout and Ovf are valid from this cycle.

Function
REQ-012 The block SHALL use a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE or DONE, start=1 at a clk edge SHALL capture A and B into shift registers, clear the borrow flop to 0, clear the bit counter to 0, and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL process one bit, LSB first: d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
  - d shifts into the result register from the MSB side.
  - Operand registers shift right.
  - The counter increments.
REQ-015 After 8 SHIFT edges (counter 0..7), the FSM SHALL enter DONE and update the outputs on that same edge:
  - Diff is loaded from the result register.
  - Bout is loaded from the final borrow.
  - Ovf = (A[7] != B[7]) && (Diff[7] != A[7]), using the captured operands.
REQ-016 Latency: when start is accepted at edge k, busy SHALL be 1 after edges k through k+7, and done SHALL be 1 (busy 0) after edge k+8.
REQ-017 In DONE, the FSM SHALL return to IDLE on the next edge unless start=1, in which case REQ-013 applies (back-to-back operation with no idle cycle).
REQ-018 start SHALL be ignored while in SHIFT; the captured operands and the in-flight result SHALL be unaffected.
REQ-019 A and B SHALL be sampled only on the accepting edge; changes to A or B afterwards SHALL NOT affect the result.
REQ-020 Diff, Bout and Ovf SHALL change only on entry to DONE or on reset, and SHALL otherwise hold their last values.
REQ-021 done SHALL be high for exactly one cycle per accepted request; busy and done SHALL never both be 1.

Reset
REQ-022 rst_n=0 at an edge SHALL force the following, regardless of state:
  - FSM to IDLE.
  - Diff=0x00, Bout=0, Ovf=0, busy=0, done=0.
  - Counter, borrow and shift registers cleared.
REQ-023 A reset asserted during SHIFT SHALL abort the operation; no done pulse SHALL follow for the aborted request.
REQ-024 start SHALL be ignored on any edge where rst_n=0.

Verification
REQ-025 A=0x98, B=0xAA, start pulse -> done 8 edges later with Diff=0xEE, Bout=1, Ovf=0.
REQ-026 A=0xAA, B=0x9F -> Diff=0x0B, Bout=0, Ovf=0; then A=0x80, B=0x01 -> Diff=0x7F, Bout=0, Ovf=1.
REQ-027 A=0x00, B=0x01 -> Diff=0xFF, Bout=1, Ovf=0; A=0x55, B=0x55 -> Diff=0x00, Bout=0, Ovf=0.
REQ-028 Start A=0x98, B=0xAA; pulse start again with A=0x11, B=0x22 during SHIFT -> second pulse ignored; result Diff=0xEE, single done pulse.
REQ-029 Start A=0x98, B=0xAA; drive rst_n=0 on the 4th SHIFT edge -> all outputs 0 on the next cycle, no done pulse; then A=0xAA, B=0x9F -> Diff=0x0B.
REQ-030 Hold start=1 continuously with A=0x80, B=0x01 -> done pulses every 9 cycles, busy low only in done cycles, Diff=0x7F each time.
